// File: rtl/board_pkg.sv
// Shared sizes and FSM encoding for the board feature analyzer.
package board_pkg;

    localparam int BLOCKS_IN_ROW = 20;
    localparam int BLOCKS_IN_COL = 10;
    localparam int CELLS         = BLOCKS_IN_ROW * BLOCKS_IN_COL;
    localparam int ROW_IDX_W     = 6;
    localparam int COL_IDX_W     = 4;
    localparam int HEIGHT_W      = 5;
    localparam int COUNT_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Absolute difference of two heights, unsigned.
    function automatic logic [HEIGHT_W-1:0] abs_diff(input logic [HEIGHT_W-1:0] a,
                                                     input logic [HEIGHT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/column_scan.sv
// Combinational per-column feature extraction: height of the top filled cell
// and the number of empty cells beneath it.
module column_scan
    import board_pkg::*;
(
    input  logic [BLOCKS_IN_ROW-1:0] column,
    output logic [HEIGHT_W-1:0]      height,
    output logic [HEIGHT_W-1:0]      holes
);

    logic [HEIGHT_W-1:0] filled;

    // Priority encode the highest set row and count filled cells.
    always_comb begin
        height = '0;
        filled = '0;
        for (int r = 0; r < BLOCKS_IN_ROW; r++) begin
            if (column[r]) begin
                height = HEIGHT_W'(r + 1);
            end
            filled = filled + {{(HEIGHT_W-1){1'b0}}, column[r]};
        end
        holes = height - filled;
    end

endmodule

// File: rtl/board_feature_analyzer.sv
// Mirrors the playfield from the row-save bus and, on request, scans a
// snapshot of it one column per cycle to produce placement-scoring features.
//
// Handshake: ready_from_analy=1 means the block is idle; a request is taken on
// any clock edge where req_analy_to_board=1, ready_from_analy=1 and
// req_save_to_board=0 (a save in the same cycle wins and the request is dropped,
// not queued). result_valid pulses for exactly one cycle when the feature
// outputs have been refreshed; there is no back-pressure on results.
module board_feature_analyzer
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_save_to_board,
    input  logic [ROW_IDX_W-1:0] row_idx,
    input  logic [BLOCKS_IN_COL-1:0] row_info,
    input  logic                 req_analy_to_board,
    output logic                 ready_from_analy,
    output logic                 result_valid,
    output logic [HEIGHT_W-1:0]  max_height,
    output logic [COUNT_W-1:0]   cumulative_height,
    output logic [HEIGHT_W-1:0]  relative_height,
    output logic [COUNT_W-1:0]   roughness,
    output logic [COUNT_W-1:0]   hole_count,
    output state_t               fsm_state
);

    state_t                  state;
    state_t                  next_state;
    logic [CELLS-1:0]        mirror;
    logic [CELLS-1:0]        snapshot;
    logic [COL_IDX_W-1:0]    col;
    logic [BLOCKS_IN_ROW-1:0] col_vec;
    logic [HEIGHT_W-1:0]     col_height;
    logic [HEIGHT_W-1:0]     col_holes;
    logic [HEIGHT_W-1:0]     h_prev;
    logic [HEIGHT_W-1:0]     max_acc;
    logic [HEIGHT_W-1:0]     min_acc;
    logic [COUNT_W-1:0]      cum_acc;
    logic [COUNT_W-1:0]      rough_acc;
    logic [COUNT_W-1:0]      holes_acc;
    logic                    accept;
    logic                    last_col;

    assign fsm_state = state;
    assign accept    = (state == ST_IDLE) && req_analy_to_board && !req_save_to_board;
    assign last_col  = (col == COL_IDX_W'(BLOCKS_IN_COL - 1));

    // Gather column `col` of the snapshot, bottom row in bit 0.
    always_comb begin
        col_vec = '0;
        for (int r = 0; r < BLOCKS_IN_ROW; r++) begin
            col_vec[r] = snapshot[r*BLOCKS_IN_COL + int'(col)];
        end
    end

    column_scan u_column_scan (
        .column (col_vec),
        .height (col_height),
        .holes  (col_holes)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: IDLE -> SCAN (10 columns) -> FINISH -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_SCAN;
            ST_SCAN:   if (last_col) next_state = ST_FINISH;
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Mirror follows the save bus in every state; out-of-range rows are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mirror <= '0;
        end else if (req_save_to_board) begin
            for (int r = 0; r < BLOCKS_IN_ROW; r++) begin
                if (row_idx == ROW_IDX_W'(r)) begin
                    mirror[r*BLOCKS_IN_COL +: BLOCKS_IN_COL] <= row_info;
                end
            end
        end
    end

    // Snapshot, column counter and running accumulators for one scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snapshot  <= '0;
            col       <= '0;
            h_prev    <= '0;
            max_acc   <= '0;
            min_acc   <= '0;
            cum_acc   <= '0;
            rough_acc <= '0;
            holes_acc <= '0;
        end else if (accept) begin
            snapshot  <= mirror;
            col       <= '0;
            h_prev    <= '0;
            max_acc   <= '0;
            min_acc   <= 5'd31;
            cum_acc   <= '0;
            rough_acc <= '0;
            holes_acc <= '0;
        end else if (state == ST_SCAN) begin
            cum_acc   <= cum_acc + {{(COUNT_W-HEIGHT_W){1'b0}}, col_height};
            holes_acc <= holes_acc + {{(COUNT_W-HEIGHT_W){1'b0}}, col_holes};
            if (col_height > max_acc) max_acc <= col_height;
            if (col_height < min_acc) min_acc <= col_height;
            if (col != '0) begin
                rough_acc <= rough_acc
                           + {{(COUNT_W-HEIGHT_W){1'b0}}, abs_diff(col_height, h_prev)};
            end
            h_prev <= col_height;
            col    <= col + 1'b1;
        end
    end

    // Result registers, handshake flags and the one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_from_analy  <= 1'b1;
            result_valid      <= 1'b0;
            max_height        <= '0;
            cumulative_height <= '0;
            relative_height   <= '0;
            roughness         <= '0;
            hole_count        <= '0;
        end else begin
            ready_from_analy <= (next_state == ST_IDLE);
            result_valid     <= 1'b0;
            if (state == ST_FINISH) begin
                result_valid      <= 1'b1;
                max_height        <= max_acc;
                cumulative_height <= cum_acc;
                relative_height   <= max_acc - min_acc;
                roughness         <= rough_acc;
                hole_count        <= holes_acc;
            end
        end
    end

endmodule
